// File: rtl/win_line_sched_pkg.sv
// ---------------------------------------------------------------------------
// win_sched_pkg
// Shared types and helpers for the line-buffer scheduler (win_line_sched).
//   sched_state_t : scheduler FSM states
//   cnt_w/rot_w   : widths of the line counter and rotation index
//   rot_mask      : cyclic window mask built from a one-hot base pointer
// ---------------------------------------------------------------------------
package win_sched_pkg;

    localparam int MAX_BUF_CNT = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_ARM   = 3'd2,
        ST_READ  = 3'd3,
        ST_FLUSH = 3'd4
    } sched_state_t;

    // Width of a counter able to hold 0..buf_cnt.
    function automatic int cnt_w(input int buf_cnt);
        return $clog2(buf_cnt + 1);
    endfunction

    // Width of a buffer index 0..buf_cnt-1 (never below one bit).
    function automatic int rot_w(input int buf_cnt);
        return (buf_cnt > 1) ? $clog2(buf_cnt) : 1;
    endfunction

    // win_size contiguous ones starting at the set bit of 'base', wrapping
    // at buf_cnt. Shifts are used instead of variable bit selects so the
    // index arithmetic stays in int without width truncation.
    function automatic logic [MAX_BUF_CNT-1:0] rot_mask(
        input logic [MAX_BUF_CNT-1:0] base,
        input int                     buf_cnt,
        input int                     win_size
    );
        logic [MAX_BUF_CNT-1:0] m;
        int                     idx;
        m = '0;
        for (int i = 0; i < MAX_BUF_CNT; i++) begin
            if ((i < buf_cnt) && (((base >> i) & MAX_BUF_CNT'(1)) != '0)) begin
                for (int k = 0; k < MAX_BUF_CNT; k++) begin
                    if (k < win_size) begin
                        idx = (i + k) % buf_cnt;
                        m   = m | (MAX_BUF_CNT'(1) << idx);
                    end
                end
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/win_line_sched_if.sv
// ---------------------------------------------------------------------------
// win_line_sched_if
// Framing inputs and line-buffer-bank control outputs of win_line_sched.
//   slave  modport : the scheduler (framing in, bank control out)
//   master modport : the surrounding datapath / stimulus
// Inputs : wr_line_end_i, frame_start_i, frame_end_i, rd_line_done_i
// Outputs: wr_buf_sel_o, rd_buf_mask_o, rd_rot_o, pop_o, discard_o,
//          lines_stored_o, busy_o, overflow_o
// With WIN_SCHED_STATS_EN defined: frame_lines_o, max_fill_o.
// ---------------------------------------------------------------------------
interface win_line_sched_if #(
    parameter int BUF_CNT = 4
) ();
    import win_sched_pkg::*;

    localparam int CW = cnt_w(BUF_CNT);
    localparam int RW = rot_w(BUF_CNT);

    logic               wr_line_end_i;
    logic               frame_start_i;
    logic               frame_end_i;
    logic               rd_line_done_i;
    logic [BUF_CNT-1:0] wr_buf_sel_o;
    logic [BUF_CNT-1:0] rd_buf_mask_o;
    logic [RW-1:0]      rd_rot_o;
    logic               pop_o;
    logic               discard_o;
    logic [CW-1:0]      lines_stored_o;
    logic               busy_o;
    logic               overflow_o;
`ifdef WIN_SCHED_STATS_EN
    logic [15:0]        frame_lines_o;
    logic [CW-1:0]      max_fill_o;
`endif

    modport slave (
        input  wr_line_end_i, frame_start_i, frame_end_i, rd_line_done_i,
        output wr_buf_sel_o, rd_buf_mask_o, rd_rot_o, pop_o, discard_o,
               lines_stored_o, busy_o, overflow_o
`ifdef WIN_SCHED_STATS_EN
        , output frame_lines_o, max_fill_o
`endif
    );

    modport master (
        output wr_line_end_i, frame_start_i, frame_end_i, rd_line_done_i,
        input  wr_buf_sel_o, rd_buf_mask_o, rd_rot_o, pop_o, discard_o,
               lines_stored_o, busy_o, overflow_o
`ifdef WIN_SCHED_STATS_EN
        , input frame_lines_o, max_fill_o
`endif
    );

endinterface

// File: rtl/win_line_sched_onehot_rot_ptr.sv
// ---------------------------------------------------------------------------
// onehot_rot_ptr
// One-hot pointer that rotates left by one position (with wrap) when en_i
// is high. Synchronous active-high reset loads bit 0.
//   clk_i, rst_i : clock, synchronous reset
//   en_i         : advance the pointer
//   ptr_o        : current one-hot pointer, W bits
// ---------------------------------------------------------------------------
module onehot_rot_ptr #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    output logic [W-1:0] ptr_o
);

    localparam logic [W-1:0] RST_VAL = W'(1);

    logic [W-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (en_i) begin
            ptr_d = {ptr_q[W-2:0], ptr_q[W-1]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= RST_VAL;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/win_line_sched.sv
// ---------------------------------------------------------------------------
// win_line_sched
// Sequences the rotating line-buffer bank of the stream-to-window datapath.
// The write pointer selects the buffer receiving the incoming line; the read
// side tracks the WIN_SIZE oldest complete lines, issues pop pulses and
// reports the rotation the datapath applies to the bank outputs.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus (slave)  : framing inputs and bank control outputs (win_line_sched_if)
// Parameters: WIN_SIZE (window height), BUF_CNT (buffers, WIN_SIZE+1..16).
// Optional feature macro: WIN_SCHED_STATS_EN (frame_lines_o, max_fill_o).
// ---------------------------------------------------------------------------
module win_line_sched
    import win_sched_pkg::*;
#(
    parameter int WIN_SIZE = 3,
    parameter int BUF_CNT  = WIN_SIZE + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    win_line_sched_if.slave  bus
);

    localparam int CW = cnt_w(BUF_CNT);
    localparam int RW = rot_w(BUF_CNT);
    localparam logic [CW-1:0] FULL_C     = CW'(BUF_CNT);
    localparam logic [CW-1:0] WIN_C      = CW'(WIN_SIZE);
    localparam logic [RW-1:0] LAST_ROT_C = RW'(BUF_CNT - 1);

    sched_state_t       state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [RW-1:0]      rot_q, rot_d;
    logic               fe_pend_q, fe_pend_d;
    logic               ovf_q, ovf_d;
    logic               pop_q, pop_d;
    logic               discard_q, discard_d;
    logic               busy_q, busy_d;
    logic [BUF_CNT-1:0] wr_sel;
    logic [BUF_CNT-1:0] rd_base;

    logic active, resync, flush_drop, rd_fire, wr_ok, wr_full, ptr_clr, fe_now;

    // A frame start while busy abandons everything; a flush with too few
    // lines for another window drops the remainder. Both return the
    // pointers to their reset positions and pulse discard_o.
    assign active     = (state_q != ST_IDLE);
    assign resync     = active && bus.frame_start_i;
    assign flush_drop = (state_q == ST_FLUSH) && (cnt_q < WIN_C) && !resync;
    assign ptr_clr    = resync || flush_drop;
    assign rd_fire    = (state_q == ST_READ) && bus.rd_line_done_i && !resync;
    assign wr_full    = (cnt_q == FULL_C);
    assign wr_ok      = active && bus.wr_line_end_i && !wr_full && !ptr_clr;
    // A frame end arriving this cycle is treated as already pending.
    assign fe_now     = fe_pend_q || bus.frame_end_i;

    onehot_rot_ptr #(.W(BUF_CNT)) u_wr_ptr (
        .clk_i (clk_i),
        .rst_i (rst_i || ptr_clr),
        .en_i  (wr_ok),
        .ptr_o (wr_sel)
    );

    onehot_rot_ptr #(.W(BUF_CNT)) u_rd_base (
        .clk_i (clk_i),
        .rst_i (rst_i || ptr_clr),
        .en_i  (rd_fire),
        .ptr_o (rd_base)
    );

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; thresholds use the registered line count
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (bus.frame_start_i) state_d = ST_FILL;
            ST_FILL: begin
                if (cnt_q >= WIN_C)  state_d = ST_ARM;
                else if (fe_now)     state_d = ST_FLUSH;
            end
            ST_ARM:   state_d = ST_READ;
            ST_READ:  if (bus.rd_line_done_i) state_d = fe_now ? ST_FLUSH : ST_FILL;
            ST_FLUSH: state_d = (cnt_q >= WIN_C) ? ST_ARM : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (resync) begin
            state_d = ST_FILL;
        end
    end

    // Output / counter next values
    always_comb begin
        cnt_d = cnt_q;
        if (wr_ok && !rd_fire) begin
            cnt_d = cnt_q + CW'(1);
        end else if (rd_fire && !wr_ok) begin
            cnt_d = cnt_q - CW'(1);
        end
        if (ptr_clr) begin
            cnt_d = '0;
        end

        rot_d = rot_q;
        if (rd_fire) begin
            rot_d = (rot_q == LAST_ROT_C) ? '0 : rot_q + RW'(1);
        end
        if (ptr_clr) begin
            rot_d = '0;
        end

        fe_pend_d = ptr_clr ? 1'b0 : (fe_pend_q || (active && bus.frame_end_i));

        ovf_d = ovf_q || (active && bus.wr_line_end_i && wr_full && !ptr_clr);
        if (resync) begin
            ovf_d = 1'b0;
        end

        pop_d     = (state_q == ST_ARM) && !resync;
        discard_d = ptr_clr;
        busy_d    = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            rot_q     <= '0;
            fe_pend_q <= 1'b0;
            ovf_q     <= 1'b0;
            pop_q     <= 1'b0;
            discard_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            rot_q     <= rot_d;
            fe_pend_q <= fe_pend_d;
            ovf_q     <= ovf_d;
            pop_q     <= pop_d;
            discard_q <= discard_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.wr_buf_sel_o   = wr_sel;
    assign bus.rd_buf_mask_o  = BUF_CNT'(rot_mask(MAX_BUF_CNT'(rd_base), BUF_CNT, WIN_SIZE));
    assign bus.rd_rot_o       = rot_q;
    assign bus.pop_o          = pop_q;
    assign bus.discard_o      = discard_q;
    assign bus.lines_stored_o = cnt_q;
    assign bus.busy_o         = busy_q;
    assign bus.overflow_o     = ovf_q;

`ifdef WIN_SCHED_STATS_EN
    logic [15:0]   cur_lines_q, cur_lines_d;
    logic [15:0]   frame_lines_q, frame_lines_d;
    logic [CW-1:0] max_fill_q, max_fill_d;

    // Lines written in the running frame; latched when the frame drains to IDLE.
    always_comb begin
        cur_lines_d = cur_lines_q;
        if (bus.frame_start_i) begin
            cur_lines_d = '0;
        end else if (wr_ok) begin
            cur_lines_d = cur_lines_q + 16'd1;
        end
        frame_lines_d = flush_drop ? cur_lines_q : frame_lines_q;
        max_fill_d    = (cnt_d > max_fill_q) ? cnt_d : max_fill_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cur_lines_q   <= '0;
            frame_lines_q <= '0;
            max_fill_q    <= '0;
        end else begin
            cur_lines_q   <= cur_lines_d;
            frame_lines_q <= frame_lines_d;
            max_fill_q    <= max_fill_d;
        end
    end

    assign bus.frame_lines_o = frame_lines_q;
    assign bus.max_fill_o    = max_fill_q;
`endif

endmodule

// File: tb/tb_win_line_sched.sv
// ---------------------------------------------------------------------------
// tb_win_line_sched
// Self-checking bench for win_line_sched (WIN_SIZE=3, BUF_CNT=4). Each
// driven cycle pushes the expected outputs of an index-based reference
// model onto a scoreboard queue; they are popped and compared one time
// unit after the clock edge. Directed checks cover the listed scenarios,
// followed by a random phase.
// ---------------------------------------------------------------------------
module tb_win_line_sched;

    localparam int WS = 3;
    localparam int BC = 4;

    localparam int S_IDLE  = 0;
    localparam int S_FILL  = 1;
    localparam int S_ARM   = 2;
    localparam int S_READ  = 3;
    localparam int S_FLUSH = 4;

    typedef struct {
        logic [3:0] sel;
        logic [3:0] mask;
        logic [1:0] rot;
        logic [2:0] cnt;
        logic       pop;
        logic       disc;
        logic       busy;
        logic       ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    win_line_sched_if #(.BUF_CNT(BC)) bus();

    win_line_sched #(.WIN_SIZE(WS), .BUF_CNT(BC)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sbq[$];

    // reference model state
    int m_state, m_cnt, m_wr, m_rd;
    bit m_fe, m_ovf, m_pop, m_disc;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_update(input bit r, input bit fs, input bit fe, input bit wl, input bit rd);
        bit fe_now, rd_go, wrote;
        int old_cnt;
        if (r) begin
            m_state = S_IDLE; m_cnt = 0; m_wr = 0; m_rd = 0;
            m_fe = 0; m_ovf = 0; m_pop = 0; m_disc = 0;
        end else if (m_state == S_IDLE) begin
            m_pop = 0; m_disc = 0;
            if (fs) m_state = S_FILL;
        end else if (fs) begin
            m_state = S_FILL; m_cnt = 0; m_wr = 0; m_rd = 0;
            m_fe = 0; m_ovf = 0; m_pop = 0; m_disc = 1;
        end else begin
            m_pop  = (m_state == S_ARM);
            m_disc = 0;
            fe_now = m_fe || fe;
            if (m_state == S_FLUSH && m_cnt < WS) begin
                m_disc = 1; m_cnt = 0; m_wr = 0; m_rd = 0; m_fe = 0;
                m_state = S_IDLE;
            end else begin
                old_cnt = m_cnt;
                rd_go = (m_state == S_READ) && rd;
                wrote = 0;
                if (wl) begin
                    if (m_cnt == BC) m_ovf = 1;
                    else begin m_wr = (m_wr + 1) % BC; wrote = 1; end
                end
                m_cnt = m_cnt + int'(wrote) - int'(rd_go);
                if (rd_go) m_rd = (m_rd + 1) % BC;
                case (m_state)
                    S_FILL:  if (old_cnt >= WS) m_state = S_ARM;
                             else if (fe_now) m_state = S_FLUSH;
                    S_ARM:   m_state = S_READ;
                    S_READ:  if (rd) m_state = fe_now ? S_FLUSH : S_FILL;
                    S_FLUSH: m_state = S_ARM;
                    default: m_state = S_IDLE;
                endcase
                m_fe = fe_now;
            end
        end
    endtask

    task automatic step(input bit r, input bit fs, input bit fe, input bit wl, input bit rd);
        exp_t e;
        int   idx;
        @(negedge clk);
        rst                = r;
        bus.frame_start_i  = fs;
        bus.frame_end_i    = fe;
        bus.wr_line_end_i  = wl;
        bus.rd_line_done_i = rd;
        model_update(r, fs, fe, wl, rd);
        e.sel  = 4'(1 << m_wr);
        e.mask = '0;
        for (int k = 0; k < WS; k++) begin
            idx    = (m_rd + k) % BC;
            e.mask = e.mask | 4'(1 << idx);
        end
        e.rot  = 2'(m_rd);
        e.cnt  = 3'(m_cnt);
        e.pop  = m_pop;
        e.disc = m_disc;
        e.busy = (m_state != S_IDLE);
        e.ovf  = m_ovf;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            chk_eq("sb_underflow", 32'd0, 32'd1);
        end else begin
            e = sbq.pop_front();
            chk_eq("wr_buf_sel",   32'(bus.wr_buf_sel_o),   32'(e.sel));
            chk_eq("rd_buf_mask",  32'(bus.rd_buf_mask_o),  32'(e.mask));
            chk_eq("rd_rot",       32'(bus.rd_rot_o),       32'(e.rot));
            chk_eq("lines_stored", 32'(bus.lines_stored_o), 32'(e.cnt));
            chk_eq("pop",          32'(bus.pop_o),          32'(e.pop));
            chk_eq("discard",      32'(bus.discard_o),      32'(e.disc));
            chk_eq("busy",         32'(bus.busy_o),         32'(e.busy));
            chk_eq("overflow",     32'(bus.overflow_o),     32'(e.ovf));
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.frame_start_i  = 1'b0;
        bus.frame_end_i    = 1'b0;
        bus.wr_line_end_i  = 1'b0;
        bus.rd_line_done_i = 1'b0;

        // reset values
        step(1, 0, 0, 0, 0);
        chk_eq("rst_sel",  32'(bus.wr_buf_sel_o),  32'h1);
        chk_eq("rst_mask", 32'(bus.rd_buf_mask_o), 32'h7);
        chk_eq("rst_busy", 32'(bus.busy_o),        32'h0);

        // line end in IDLE is ignored
        step(0, 0, 0, 1, 0);
        chk_eq("idle_wl_cnt", 32'(bus.lines_stored_o), 32'h0);

        // first frame: three lines then one pop
        step(0, 1, 0, 0, 0);
        repeat (3) step(0, 0, 0, 1, 0);
        idle();
        chk_eq("arm_nopop", 32'(bus.pop_o), 32'h0);
        idle();
        chk_eq("tp1_pop",  32'(bus.pop_o),         32'h1);
        chk_eq("tp1_rot",  32'(bus.rd_rot_o),      32'h0);
        chk_eq("tp1_mask", 32'(bus.rd_buf_mask_o), 32'h7);
        idle();

        // read done together with a 4th line end
        step(0, 0, 0, 1, 1);
        chk_eq("tp2_cnt",  32'(bus.lines_stored_o), 32'h3);
        chk_eq("tp2_rot",  32'(bus.rd_rot_o),       32'h1);
        chk_eq("tp2_mask", 32'(bus.rd_buf_mask_o),  32'he);
        chk_eq("tp2_sel",  32'(bus.wr_buf_sel_o),   32'h1);
        idle();
        idle();
        chk_eq("tp2_pop", 32'(bus.pop_o), 32'h1);

        // fill to capacity and overflow inside READ
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        chk_eq("ovf_set", 32'(bus.overflow_o),   32'h1);
        chk_eq("ovf_sel", 32'(bus.wr_buf_sel_o), 32'h2);

        // resync mid-READ
        step(0, 1, 0, 0, 0);
        chk_eq("rs_disc", 32'(bus.discard_o),    32'h1);
        chk_eq("rs_sel",  32'(bus.wr_buf_sel_o), 32'h1);
        chk_eq("rs_rot",  32'(bus.rd_rot_o),     32'h0);
        chk_eq("rs_ovf",  32'(bus.overflow_o),   32'h0);

        // five line ends without reads
        repeat (4) step(0, 0, 0, 1, 0);
        chk_eq("tp3_cnt4", 32'(bus.lines_stored_o), 32'h4);
        step(0, 0, 0, 1, 0);
        chk_eq("tp3_ovf", 32'(bus.overflow_o),   32'h1);
        chk_eq("tp3_sel", 32'(bus.wr_buf_sel_o), 32'h1);

        // frame end leaving too few lines -> discard and IDLE
        step(0, 0, 0, 0, 1);
        idle();
        idle();
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1);
        idle();
        chk_eq("fe_disc", 32'(bus.discard_o),      32'h1);
        chk_eq("fe_cnt",  32'(bus.lines_stored_o), 32'h0);
        chk_eq("fe_busy", 32'(bus.busy_o),         32'h0);

        // frame end with enough lines -> another pop before the drop
        step(0, 1, 0, 0, 0);
        repeat (4) step(0, 0, 0, 1, 0);
        idle();
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1);
        idle();
        idle();
        chk_eq("fe_repop", 32'(bus.pop_o), 32'h1);
        step(0, 0, 0, 0, 1);
        idle();
        chk_eq("fe_disc2", 32'(bus.discard_o), 32'h1);

        // simultaneous start and end while active: start wins
        step(0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        repeat (3) step(0, 0, 0, 1, 0);
        idle();
        idle();
        step(0, 0, 0, 0, 1);
        idle();
        chk_eq("se_nodisc", 32'(bus.discard_o), 32'h0);
        chk_eq("se_busy",   32'(bus.busy_o),    32'h1);

        // reset during READ, then a stray read done
        step(0, 0, 0, 1, 0);
        idle();
        idle();
        step(1, 0, 0, 0, 0);
        chk_eq("mrst_cnt",  32'(bus.lines_stored_o), 32'h0);
        chk_eq("mrst_busy", 32'(bus.busy_o),         32'h0);
        step(0, 0, 0, 0, 1);
        chk_eq("stray_rot", 32'(bus.rd_rot_o), 32'h0);

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 59) == 0,
                 $urandom_range(0, 39) == 0,
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 2)  == 0,
                 $urandom_range(0, 3)  == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
